// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the multicycle CPU datapath and its controller:
//   - major opcodes decoded by the controller (instr[6:0])
//   - immediate-format select encodings (also consumed by the immediate
//     generator, so the values must stay in sync with it)
//   - controller state encoding
//   - small decode helpers used by the controller
// ---------------------------------------------------------------------------
package cpu_pkg;

   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;
   localparam logic [6:0] OPC_OP    = 7'b0110011;

   localparam logic [1:0] IMM_NONE = 2'b00;
   localparam logic [1:0] IMM_I    = 2'b01;
   localparam logic [1:0] IMM_S    = 2'b10;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } state_t;

   // True for the four opcodes this controller knows how to sequence.
   function automatic logic opc_legal(input logic [6:0] opc);
      logic r;
      case (opc)
         OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_OP: r = 1'b1;
         default:                                r = 1'b0;
      endcase
      return r;
   endfunction

   // Immediate format needed by an opcode (R-type needs none).
   function automatic logic [1:0] imm_sel_for(input logic [6:0] opc);
      logic [1:0] r;
      case (opc)
         OPC_OPIMM, OPC_LOAD: r = IMM_I;
         OPC_STORE:           r = IMM_S;
         default:             r = IMM_NONE;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// ---------------------------------------------------------------------------
// mem_wait_timer
// Counts consecutive cycles in which a memory request is outstanding
// without being accepted, and flags the cycle in which the wait reaches
// TIMEOUT_CYCLES. Any cycle that is not a wait cycle (handshake or no
// request) restarts the count.
//
// Parameters:
//   TIMEOUT_CYCLES  wait cycles allowed before expiry; 0 disables expiry
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   waiting  in   mem_req=1 and mem_ready=0 this cycle
//   expired  out  this wait cycle is the TIMEOUT_CYCLES-th in a row
// ---------------------------------------------------------------------------
module mem_wait_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic waiting,
   output logic expired
);

   // count_r holds the number of wait cycles already completed, so the
   // limit compare is against TIMEOUT_CYCLES-1 while the current cycle waits.
   localparam int unsigned CW    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
   localparam int unsigned LIMIT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
   localparam logic [CW-1:0] LIMIT_V = CW'(LIMIT);

   logic [CW-1:0] count_r;

   // Wait-cycle counter: advances while waiting, restarts otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r <= {CW{1'b0}};
      end else if (waiting && !expired) begin
         count_r <= count_r + CW'(1);
      end else begin
         count_r <= {CW{1'b0}};
      end
   end

   if (TIMEOUT_CYCLES == 0) begin : g_timeout_off
      assign expired = 1'b0;
   end else begin : g_timeout_on
      assign expired = waiting && (count_r == LIMIT_V);
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Sequencing FSM for the multicycle CPU datapath. Steps each instruction
// through FETCH, DECODE, EXEC, (MEM), (WB) and drives the datapath strobes.
// All arithmetic lives in the datapath; this block only sequences.
//
// Parameters:
//   TIMEOUT_CYCLES  max wait cycles for mem_ready before a bus-error trap
//                   (0 disables the timeout)
//   HALT_ON_TRAP    1: TRAP is terminal until reset; 0: TRAP -> FETCH
// Ports:
//   clk, rst       clock (rising edge), synchronous active-high reset
//   instr[31:0]    current IR contents (only sampled in DECODE)
//   mem_ready      memory accepted/completed the current request
//   ir_we, pc_we   load IR / advance PC (fetch handshake cycle)
//   mem_req        memory request valid (FETCH, MEM)
//   mem_we         request is a store
//   mem_addr_sel   0 = PC, 1 = ALU result
//   imm_sel[1:0]   immediate format (IMM_NONE / IMM_I / IMM_S)
//   alu_src_b      0 = rs2, 1 = immediate
//   reg_we         register-file write strobe (WB)
//   wb_sel         0 = ALU result, 1 = load data
//   trap           sticky illegal-opcode / memory-timeout flag
//   busy           low only in FETCH while idle since reset
// Optional build macro MULTICYCLE_CTRL_PERF_EN adds:
//   instret[31:0]       retired-instruction counter
//   stall_cycles[31:0]  memory wait-cycle counter
//
// Outputs are combinational from the state and the opcode registered in
// DECODE (plus mem_ready for the fetch write enables); none depend on instr.
// ---------------------------------------------------------------------------
module multicycle_ctrl
   import cpu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter bit          HALT_ON_TRAP   = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic        mem_ready,
   output logic        ir_we,
   output logic        pc_we,
   output logic        mem_req,
   output logic        mem_we,
   output logic        mem_addr_sel,
   output logic [1:0]  imm_sel,
   output logic        alu_src_b,
   output logic        reg_we,
   output logic        wb_sel,
   output logic        trap,
   output logic        busy
`ifdef MULTICYCLE_CTRL_PERF_EN
   ,
   output logic [31:0] instret,
   output logic [31:0] stall_cycles
`endif
);

   state_t     state_r;
   state_t     state_nxt_s;
   logic [6:0] opc_r;
   logic       trap_r;
   logic       trap_set_s;
   logic       idle_r;
   logic       wait_s;
   logic       hs_s;
   logic       expired_s;
   logic       unused_instr_s;

   // Only the opcode field is decoded here; the rest belongs to the datapath.
   assign unused_instr_s = ^instr[31:7];

   assign wait_s = mem_req & ~mem_ready;
   assign hs_s   = mem_req & mem_ready;

   mem_wait_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .waiting (wait_s),
      .expired (expired_s)
   );

   // State, opcode, sticky trap and post-reset idle registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_FETCH;
         opc_r   <= 7'b0000000;
         trap_r  <= 1'b0;
         idle_r  <= 1'b1;
      end else begin
         state_r <= state_nxt_s;
         if (state_r == ST_DECODE) begin
            opc_r <= instr[6:0];
         end else begin
            opc_r <= opc_r;
         end
         trap_r <= trap_r | trap_set_s;
         // Idle ends with the first accepted fetch after reset.
         if ((state_r == ST_FETCH) && hs_s) begin
            idle_r <= 1'b0;
         end else begin
            idle_r <= idle_r;
         end
      end
   end

   // Next-state logic; a handshake always beats an expiring timer because
   // expired_s is only ever raised in a cycle where mem_ready is low.
   always_comb begin
      state_nxt_s = state_r;
      trap_set_s  = 1'b0;
      case (state_r)
         ST_FETCH: begin
            if (hs_s) begin
               state_nxt_s = ST_DECODE;
            end else if (expired_s) begin
               state_nxt_s = ST_TRAP;
               trap_set_s  = 1'b1;
            end else begin
               state_nxt_s = ST_FETCH;
            end
         end
         ST_DECODE: begin
            // instr is decoded directly here; opc_r is loaded on this edge.
            if (opc_legal(instr[6:0])) begin
               state_nxt_s = ST_EXEC;
            end else begin
               state_nxt_s = ST_TRAP;
               trap_set_s  = 1'b1;
            end
         end
         ST_EXEC: begin
            if ((opc_r == OPC_LOAD) || (opc_r == OPC_STORE)) begin
               state_nxt_s = ST_MEM;
            end else begin
               state_nxt_s = ST_WB;
            end
         end
         ST_MEM: begin
            if (hs_s) begin
               if (opc_r == OPC_STORE) begin
                  state_nxt_s = ST_FETCH;
               end else begin
                  state_nxt_s = ST_WB;
               end
            end else if (expired_s) begin
               state_nxt_s = ST_TRAP;
               trap_set_s  = 1'b1;
            end else begin
               state_nxt_s = ST_MEM;
            end
         end
         ST_WB: begin
            state_nxt_s = ST_FETCH;
         end
         ST_TRAP: begin
            if (HALT_ON_TRAP) begin
               state_nxt_s = ST_TRAP;
            end else begin
               state_nxt_s = ST_FETCH;
            end
         end
         default: begin
            state_nxt_s = ST_FETCH;
         end
      endcase
   end

   // Datapath strobes decoded from state and the registered opcode.
   always_comb begin
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      imm_sel      = IMM_NONE;
      alu_src_b    = 1'b0;
      reg_we       = 1'b0;
      wb_sel       = 1'b0;
      case (state_r)
         ST_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_we = 1'b1;
               pc_we = 1'b1;
            end else begin
               ir_we = 1'b0;
               pc_we = 1'b0;
            end
         end
         ST_DECODE: begin
            ir_we = 1'b0;
         end
         ST_EXEC: begin
            imm_sel   = imm_sel_for(opc_r);
            alu_src_b = (opc_r != OPC_OP);
         end
         ST_MEM: begin
            // Address operands from EXEC stay selected for the whole access.
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
            mem_we       = (opc_r == OPC_STORE);
            imm_sel      = imm_sel_for(opc_r);
            alu_src_b    = 1'b1;
         end
         ST_WB: begin
            reg_we = 1'b1;
            wb_sel = (opc_r == OPC_LOAD);
         end
         ST_TRAP: begin
            reg_we = 1'b0;
         end
         default: begin
            reg_we = 1'b0;
         end
      endcase
   end

   assign trap = trap_r;
   assign busy = ~((state_r == ST_FETCH) && idle_r);

`ifdef MULTICYCLE_CTRL_PERF_EN
   logic [31:0] instret_r;
   logic [31:0] stall_r;
   logic        retire_s;

   // An instruction retires when control re-enters FETCH after completing.
   assign retire_s = (state_r == ST_WB) ||
                     ((state_r == ST_MEM) && hs_s && (opc_r == OPC_STORE));

   // Free-running performance counters, wrapping at 2^32.
   always_ff @(posedge clk) begin
      if (rst) begin
         instret_r <= 32'd0;
         stall_r   <= 32'd0;
      end else begin
         if (retire_s) begin
            instret_r <= instret_r + 32'd1;
         end else begin
            instret_r <= instret_r;
         end
         if (wait_s) begin
            stall_r <= stall_r + 32'd1;
         end else begin
            stall_r <= stall_r;
         end
      end
   end

   assign instret      = instret_r;
   assign stall_cycles = stall_r;
`endif

endmodule
